// File: rtl/elevator_request_dispatcher.sv
// SCAN request dispatcher: latches floor calls, picks the next target in the
// current sweep direction, and holds the door open for a fixed dwell on arrival.
module elevator_request_dispatcher #(
  parameter int unsigned NUM_FLOORS   = 16,
  parameter int unsigned DWELL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        call_valid,
  input  logic [3:0]  call_floor,
  input  logic [3:0]  currentFloor,
  output logic [3:0]  requestFloor,
  output logic [15:0] pending,
  output logic        busy,
  output logic        door_open,
  output logic        dir_up
);

  localparam int unsigned CW = $clog2(DWELL_CYCLES + 1);
  localparam logic [4:0]    NF       = 5'(NUM_FLOORS);
  localparam logic [CW-1:0] DWELL_LD = CW'(DWELL_CYCLES);

  typedef enum logic [1:0] {IDLE, TRAVEL, DWELL} state_e;

  state_e        state_q, state_d;
  logic [15:0]   pend_q, pend_d;
  logic [3:0]    req_q, req_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          call_ok, call_here;
  logic [15:0]   set_mask, clr_mask;
  logic          up_found, dn_found;
  logic [3:0]    up_sel, dn_sel;

  // A repeat call for the floor being served extends the dwell instead of latching.
  assign call_ok   = call_valid && ({1'b0, call_floor} < NF);
  assign call_here = (state_q == DWELL) && call_ok && (call_floor == currentFloor);
  assign set_mask  = (call_ok && !call_here) ? (16'(1) << call_floor) : '0;

  // Nearest pending floor strictly above and strictly below the car.
  always_comb begin
    up_found = 1'b0;
    dn_found = 1'b0;
    up_sel   = '0;
    dn_sel   = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (pend_q[i] && (4'(i) < currentFloor)) begin
        dn_found = 1'b1;
        dn_sel   = 4'(i);
      end
    end
    for (int unsigned i = 16; i > 0; i--) begin
      if (pend_q[i-1] && (4'(i-1) > currentFloor)) begin
        up_found = 1'b1;
        up_sel   = 4'(i-1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    clr_mask = '0;
    case (state_q)
      IDLE: begin
        if (pend_q != '0) begin
          if (pend_q[currentFloor]) begin
            clr_mask[currentFloor] = 1'b1;
            cnt_d   = DWELL_LD;
            state_d = DWELL;
          end else begin
            state_d = TRAVEL;
            if (dir_q ? up_found : dn_found) begin
              req_d = dir_q ? up_sel : dn_sel;
            end else begin
              dir_d = ~dir_q;
              req_d = dir_q ? dn_sel : up_sel;
            end
          end
        end
      end
      TRAVEL: begin
        if (currentFloor == req_q) begin
          clr_mask[req_q] = 1'b1;
          cnt_d   = DWELL_LD;
          state_d = DWELL;
        end else if (req_q > currentFloor) begin
          if (up_found && (up_sel < req_q)) req_d = up_sel;
        end else begin
          if (dn_found && (dn_sel > req_q)) req_d = dn_sel;
        end
      end
      DWELL: begin
        if (call_here) begin
          cnt_d = DWELL_LD;
        end else if (cnt_q == CW'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    pend_d = (pend_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      req_q   <= '0;
      dir_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      req_q   <= req_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign requestFloor = req_q;
  assign pending      = pend_q;
  assign busy         = (state_q != IDLE);
  assign door_open    = (state_q == DWELL);
  assign dir_up       = dir_q;

endmodule

// File: tb/tb_elevator_request_dispatcher.sv
// Scoreboard bench: a floor-distance reference model predicts each cycle's
// outputs, and an independent monitor compares them after every clock edge.
module tb_elevator_request_dispatcher;

  localparam int NF = 12;
  localparam int DW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        call_valid = 1'b0;
  logic [3:0]  call_floor = '0;
  logic [3:0]  currentFloor = '0;
  logic [3:0]  requestFloor;
  logic [15:0] pending;
  logic        busy, door_open, dir_up;

  elevator_request_dispatcher #(.NUM_FLOORS(NF), .DWELL_CYCLES(DW)) dut (
    .clk(clk), .rst_n(rst_n), .call_valid(call_valid), .call_floor(call_floor),
    .currentFloor(currentFloor), .requestFloor(requestFloor), .pending(pending),
    .busy(busy), .door_open(door_open), .dir_up(dir_up)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  req;
    logic [15:0] pend;
    logic        busy;
    logic        door;
    logic        dir;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: 0 = idle, 1 = moving to target, 2 = door open
  int       m_mode;
  bit [15:0] m_pend;
  int       m_req;
  bit       m_dir;
  int       m_left;
  int       m_pos;
  bit       tick;

  function automatic int search(int cur, bit up);
    int f;
    for (int d = 1; d < 16; d++) begin
      f = up ? cur + d : cur - d;
      if (f >= 0 && f < NF && m_pend[f]) return f;
    end
    return -1;
  endfunction

  task automatic model_update(input bit cv, input int cf, input int cur);
    bit ok, blocked;
    int f;
    bit go_up;
    ok = cv && (cf < NF);
    blocked = (m_mode == 2) && ok && (cf == cur);
    case (m_mode)
      0: if (m_pend != 0) begin
        if (m_pend[cur]) begin
          m_pend[cur] = 1'b0;
          m_mode = 2;
          m_left = DW;
        end else begin
          f = search(cur, m_dir);
          if (f < 0) begin
            m_dir = !m_dir;
            f = search(cur, m_dir);
          end
          m_req = f;
          m_mode = 1;
        end
      end
      1: if (cur == m_req) begin
        m_pend[m_req] = 1'b0;
        m_mode = 2;
        m_left = DW;
      end else begin
        go_up = m_req > cur;
        f = search(cur, go_up);
        if (f >= 0 && (go_up ? f < m_req : f > m_req)) m_req = f;
      end
      default: begin
        if (blocked) m_left = DW;
        else if (m_left == 1) m_mode = 0;
        else m_left = m_left - 1;
      end
    endcase
    if (ok && !blocked) m_pend[cf] = 1'b1;
  endtask

  task automatic model_reset();
    m_mode = 0; m_pend = '0; m_req = 0; m_dir = 1'b1; m_left = 0;
  endtask

  task automatic step(input bit cv, input int cf);
    exp_t e;
    @(negedge clk);
    if (m_mode == 1 && tick) m_pos = (m_req > m_pos) ? m_pos + 1 : (m_req < m_pos ? m_pos - 1 : m_pos);
    tick = !tick;
    call_valid   = cv;
    call_floor   = 4'(cf);
    currentFloor = 4'(m_pos);
    model_update(cv, cf, m_pos);
    e.req  = 4'(m_req);
    e.pend = m_pend;
    e.busy = (m_mode != 0);
    e.door = (m_mode == 2);
    e.dir  = m_dir;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int k = 0; k < 600 && !(m_mode == 0 && m_pend == 0); k++) step(0, 0);
    step(0, 0);
  endtask

  // Reset is asserted between edges; outputs must clear without a clock.
  task automatic apply_reset();
    exp_t a;
    @(negedge clk);
    call_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    a = {requestFloor, pending, busy, door_open, dir_up};
    vectors++;
    if (a !== {4'd0, 16'd0, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL async_reset t=%0t got req=%0d pend=%h busy=%b door=%b dir=%b, expected req=0 pend=0000 busy=0 door=0 dir=1",
               $time, requestFloor, pending, busy, door_open, dir_up);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {requestFloor, pending, busy, door_open, dir_up};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t got req=%0d pend=%h busy=%b door=%b dir=%b, expected req=%0d pend=%h busy=%b door=%b dir=%b",
                   $time, a.req, a.pend, a.busy, a.door, a.dir, e.req, e.pend, e.busy, e.door, e.dir);
        end
      end
    end
  end

  initial begin : stimulus
    model_reset();
    m_pos = 0;
    tick = 1'b0;
    apply_reset();
    repeat (5) step(0, 0);

    // Long trip 0 -> 10, intercepted by a call for 5 while passing floor 3
    step(1, 10);
    for (int k = 0; k < 100 && m_pos != 3; k++) step(0, 0);
    step(1, 5);
    drain();

    // Reset while travelling with three calls outstanding
    step(1, 3);
    step(1, 7);
    step(1, 1);
    step(0, 0);
    apply_reset();
    m_pos = 0;

    // Car parked at 5 heading up with calls 2 and 8: serve 8, reverse, serve 2
    step(1, 5);
    for (int k = 0; k < 100 && m_mode != 2; k++) step(0, 0);
    step(1, 2);
    step(1, 8);
    drain();

    // Call for the current floor, repeat during dwell, out-of-range calls
    step(1, m_pos);
    step(0, 0);
    step(1, m_pos);
    step(0, 0);
    step(1, m_pos);
    step(1, 15);
    step(1, 12);
    drain();

    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) apply_reset();
      step($urandom_range(0, 5) == 0, int'($urandom_range(0, 15)));
    end
    drain();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
